// File: rtl/atari_video_pkg.sv
// Shared video constants, RGB222 type and the NTSC-to-RGB222 palette for the Atari 2600 display path.
package atari_video_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int TIA_WIDTH = 160;
  localparam int X_SCALE   = 4;
  localparam int XS_SHIFT  = $clog2(X_SCALE);
  localparam int COLOR_W   = 7;
  localparam int PTR_W     = 8;

  // Counter-width copies so comparisons stay width-matched
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [PTR_W-1:0] TIA_LEN = PTR_W'(TIA_WIDTH);

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  function automatic rgb222_t hue_base(input logic [3:0] hue);
    case (hue)
      4'd1:    return 6'b111111;
      4'd2:    return 6'b111000;
      4'd3:    return 6'b110100;
      4'd4:    return 6'b110001;
      4'd5:    return 6'b110011;
      4'd6:    return 6'b100011;
      4'd7:    return 6'b010011;
      4'd8:    return 6'b000011;
      4'd9:    return 6'b000111;
      4'd10:   return 6'b001111;
      4'd11:   return 6'b001110;
      4'd12:   return 6'b001100;
      4'd13:   return 6'b011100;
      4'd14:   return 6'b101100;
      4'd15:   return 6'b111101;
      default: return 6'b000000;
    endcase
  endfunction

  // Channel scaled by (lum+1)/8, so lum 7 returns the base value unchanged
  function automatic logic [1:0] scale_chan(input logic [1:0] c, input logic [2:0] lum);
    logic [4:0] p;
    p = {3'b000, c} * ({2'b00, lum} + 5'd1);
    return 2'(p >> 3);
  endfunction

  function automatic rgb222_t ntsc_to_rgb222(input logic [COLOR_W-1:0] color);
    rgb222_t base;
    rgb222_t res;
    base = hue_base(color[6:3]);
    if (color[6:3] == 4'd0) begin
      res = {color[2:1], color[2:1], color[2:1]};
    end else begin
      res.r = scale_chan(base.r, color[2:0]);
      res.g = scale_chan(base.g, color[2:0]);
      res.b = scale_chan(base.b, color[2:0]);
    end
    return res;
  endfunction

endpackage

// File: rtl/tia_vga_line_doubler_if.sv
// TIA pixel stream in, VGA pins and drop indication out.
interface tia_vga_if;
  logic       tia_pixel_valid;
  logic [6:0] tia_pixel_color;
  logic       tia_line_start;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [5:0] vga_rgb;
  logic       line_dropped;

  modport master (
    output tia_pixel_valid, tia_pixel_color, tia_line_start,
    input  vga_hsync, vga_vsync, vga_rgb, line_dropped
  );

  modport slave (
    input  tia_pixel_valid, tia_pixel_color, tia_line_start,
    output vga_hsync, vga_vsync, vga_rgb, line_dropped
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 counters with raw sync, visible and line-pair start.
// SCANLINES_EN adds an odd_line output for the scanline dimming.
module vga_timing
  import atari_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible,
`ifdef SCANLINES_EN
  output logic       odd_line,
`endif
  output logic       pair_start
);
  logic [9:0] v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hsync_raw  = !(h_cnt >= HS_START && h_cnt < HS_END);
  assign vsync_raw  = !(v_cnt >= VS_START && v_cnt < VS_END);
  assign visible    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign pair_start = (h_cnt == H_LAST) && (!v_cnt[0] || v_cnt == V_LAST);
`ifdef SCANLINES_EN
  assign odd_line   = v_cnt[0];
`endif
endmodule

// File: rtl/tia_vga_line_doubler.sv
// Ping-pong line buffer: one TIA line replayed on two VGA lines, pixels widened 4x, palette mapped.
// Define SCANLINES_EN to dim the odd line of each pair.
module tia_vga_line_doubler
  import atari_video_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  tia_vga_if.slave bus
);
  logic [9:0]         h_cnt;
  logic               hsync_raw, vsync_raw, visible, pair_start;
  logic [COLOR_W-1:0] line_buf [2][TIA_WIDTH];
  logic               disp_bank, pending, buf_valid, pend_eff;
  logic [PTR_W-1:0]   wr_ptr, rd_addr;
  logic [COLOR_W-1:0] pix_p1;
  logic               vld_p1, hs_p1, vs_p1;
  rgb222_t            rgb_c;
`ifdef SCANLINES_EN
  logic               odd_line, odd_p1;
`endif

  vga_timing u_timing (
    .clk        (clk),
    .reset      (reset),
    .h_cnt      (h_cnt),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .visible    (visible),
`ifdef SCANLINES_EN
    .odd_line   (odd_line),
`endif
    .pair_start (pair_start)
  );

  function automatic logic [PTR_W-1:0] sat_inc(input logic [PTR_W-1:0] p);
    return (p >= TIA_LEN) ? p : p + PTR_W'(1);
  endfunction

`ifdef SCANLINES_EN
  function automatic rgb222_t scan_dim(input rgb222_t c);
    return {1'b0, c.r[1], 1'b0, c.g[1], 1'b0, c.b[1]};
  endfunction
`endif

  // A line start coinciding with a pair start hands the old line to the display first
  assign pend_eff = pending && !pair_start;
  assign rd_addr  = visible ? PTR_W'(h_cnt >> XS_SHIFT) : '0;

  always_ff @(posedge clk) begin
    if (bus.tia_pixel_valid && wr_ptr < TIA_LEN)
      line_buf[~disp_bank][wr_ptr] <= bus.tia_pixel_color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_bank        <= 1'b0;
      pending          <= 1'b0;
      buf_valid        <= 1'b0;
      wr_ptr           <= '0;
      bus.line_dropped <= 1'b0;
    end else begin
      bus.line_dropped <= bus.tia_line_start && pend_eff;
      if (pair_start && pending) begin
        disp_bank <= ~disp_bank;
        buf_valid <= 1'b1;
      end
      if (bus.tia_line_start)
        pending <= 1'b1;
      else if (pair_start)
        pending <= 1'b0;
      if (bus.tia_line_start)
        wr_ptr <= '0;
      else if (bus.tia_pixel_valid)
        wr_ptr <= sat_inc(wr_ptr);
    end
  end

  // Stage p1: buffer read, timing flags delayed alongside
  always_ff @(posedge clk) begin
    pix_p1 <= line_buf[disp_bank][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
`ifdef SCANLINES_EN
      odd_p1 <= 1'b0;
`endif
    end else begin
      vld_p1 <= visible;
      hs_p1  <= hsync_raw;
      vs_p1  <= vsync_raw;
`ifdef SCANLINES_EN
      odd_p1 <= odd_line;
`endif
    end
  end

  always_comb begin
    rgb_c = ntsc_to_rgb222(pix_p1);
`ifdef SCANLINES_EN
    if (odd_p1)
      rgb_c = scan_dim(rgb_c);
`endif
  end

  // Stage p2: palette result and syncs registered onto the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.vga_hsync <= 1'b1;
      bus.vga_vsync <= 1'b1;
      bus.vga_rgb   <= '0;
    end else begin
      bus.vga_hsync <= hs_p1;
      bus.vga_vsync <= vs_p1;
      bus.vga_rgb   <= (vld_p1 && buf_valid) ? rgb_c : 6'b000000;
    end
  end
endmodule

// File: tb/tb_tia_vga_line_doubler.sv
// Directed bench for tia_vga_line_doubler: reset, timing, buffering, drop and saturation cases.
module tb_tia_vga_line_doubler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n;
  int   total = 0;
  int   bad = 0;
  int   ld_cnt = 0;

  tia_vga_if bus ();

  tia_vga_line_doubler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  // n = clock edges since reset release; pins show counter position n-2
  always @(posedge clk) begin
    if (reset) n <= 0;
    else n <= n + 1;
    if (bus.line_dropped === 1'b1) ld_cnt <= ld_cnt + 1;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: no finish within cycle budget");
    $fatal(1);
  end

  typedef struct {
    int         pix;
    logic [5:0] rgb;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [5:0] shown(input logic [5:0] base, input int line);
`ifdef SCANLINES_EN
    if (line % 2 == 1) return {1'b0, base[5], 1'b0, base[3], 1'b0, base[1]};
`endif
    return base;
  endfunction

  task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic wait_pos(input int p);
    while (n < p + 2) @(negedge clk);
    if (n != p + 2) begin
      total++;
      bad++;
      $display("FAIL sequencing: at n=%0d want n=%0d", n, p + 2);
    end
  endtask

  task automatic px(input logic [6:0] c, input logic ls);
    bus.tia_pixel_valid = 1'b1;
    bus.tia_pixel_color = c;
    bus.tia_line_start  = ls;
    @(negedge clk);
    bus.tia_pixel_valid = 1'b0;
    bus.tia_line_start  = 1'b0;
  endtask

  task automatic line_start();
    bus.tia_line_start = 1'b1;
    @(negedge clk);
    bus.tia_line_start = 1'b0;
  endtask

  task automatic check_line(input int line, input logic [5:0] base);
    int e_rgb = 0;
    int e_sync = 0;
    int v;
    logic [5:0] exp;
    logic hs_e, vs_e;
    v = line % 525;
    for (int h = 0; h < 800; h++) begin
      wait_pos(800 * line + h);
      exp  = (h < 640) ? shown(base, line) : 6'b000000;
      hs_e = !(h >= 656 && h < 752);
      vs_e = !(v >= 490 && v < 492);
      if (bus.vga_rgb !== exp) e_rgb++;
      if (bus.vga_hsync !== hs_e || bus.vga_vsync !== vs_e) e_sync++;
    end
    check_int($sformatf("line%0d rgb errors", line), e_rgb, 0);
    check_int($sformatf("line%0d sync errors", line), e_sync, 0);
  endtask

  initial begin
    int ld_base;
    vecs[0]  = '{0,   6'b000000};
    vecs[1]  = '{5,   6'b101010};
    vecs[2]  = '{7,   6'b111111};
    vecs[3]  = '{11,  6'b010101};
    vecs[4]  = '{15,  6'b111111};
    vecs[5]  = '{21,  6'b100100};
    vecs[6]  = '{39,  6'b110001};
    vecs[7]  = '{71,  6'b000011};
    vecs[8]  = '{100, 6'b000100};
    vecs[9]  = '{127, 6'b111101};
    vecs[10] = '{130, 6'b010101};
    vecs[11] = '{159, 6'b110100};

    bus.tia_pixel_valid = 1'b0;
    bus.tia_pixel_color = 7'h00;
    bus.tia_line_start  = 1'b0;
    repeat (4) @(negedge clk);
    check6("reset hsync", {5'b0, bus.vga_hsync}, 6'd1);
    check6("reset vsync", {5'b0, bus.vga_vsync}, 6'd1);
    check6("reset rgb", bus.vga_rgb, 6'd0);
    check6("reset line_dropped", {5'b0, bus.line_dropped}, 6'd0);
    reset = 1'b0;

    // Idle lines: timing only, nothing buffered
    for (int l = 0; l < 3; l++) check_line(l, 6'b000000);

    // One grey line, shown on lines 5 and 6 after the pair start ending line 4
    for (int i = 0; i < 160; i++) px(7'h0F, 1'b0);
    line_start();
    check_line(4, 6'b000000);
    check_line(5, 6'b111111);
    check_line(6, 6'b111111);

    // Ramp line, shown on lines 9 and 10
    for (int i = 0; i < 160; i++) px(7'(i), 1'b0);
    line_start();
    check_line(8, 6'b111111);
    for (int k = 0; k < 12; k++) begin
      wait_pos(7200 + 4 * vecs[k].pix);
      check6($sformatf("ramp px%0d left", vecs[k].pix), bus.vga_rgb, shown(vecs[k].rgb, 9));
      wait_pos(7200 + 4 * vecs[k].pix + 3);
      check6($sformatf("ramp px%0d right", vecs[k].pix), bus.vga_rgb, shown(vecs[k].rgb, 9));
    end
    wait_pos(8000 + 84);
    check6("ramp repeat line px21", bus.vga_rgb, 6'b100100);

    // Two line starts before a pair start; last pixel shares the cycle with the second
    check_int("no drop so far", ld_cnt, 0);
    wait_pos(8798);
    ld_base = ld_cnt;
    for (int i = 0; i < 160; i++) px(7'h07, 1'b0);
    line_start();
    repeat (3) @(negedge clk);
    check_int("no drop on first start", ld_cnt - ld_base, 0);
    for (int i = 0; i < 159; i++) px(7'h02, 1'b0);
    px(7'h27, 1'b1);
    repeat (3) @(negedge clk);
    check_int("drop on second start", ld_cnt - ld_base, 1);
    wait_pos(9600 + 84);
    check6("no swap before pair start", bus.vga_rgb, 6'b100100);
    wait_pos(10400);
    check6("second line px0 odd", bus.vga_rgb, shown(6'b010101, 13));
    wait_pos(10400 + 636);
    check6("same-cycle px159 odd", bus.vga_rgb, shown(6'b110001, 13));
    wait_pos(11200);
    check6("second line px0 even", bus.vga_rgb, 6'b010101);
    wait_pos(11200 + 320);
    check6("second line px80 even", bus.vga_rgb, 6'b010101);
    wait_pos(11200 + 639);
    check6("same-cycle px159 even", bus.vga_rgb, 6'b110001);

    // 200 pixels: the 40 extra must not land anywhere
    wait_pos(11998);
    for (int i = 0; i < 160; i++) px(7'h27, 1'b0);
    for (int i = 0; i < 40; i++) px(7'h07, 1'b0);
    line_start();
    check_line(18, 6'b110001);
    check_int("drops after overlong line", ld_cnt - ld_base, 1);

    // Reset mid visible line
    wait_pos(15200 + 300);
    check6("pre-reset rgb", bus.vga_rgb, shown(6'b110001, 19));
    reset = 1'b1;
    @(negedge clk);
    check6("mid reset rgb", bus.vga_rgb, 6'd0);
    check6("mid reset hsync", {5'b0, bus.vga_hsync}, 6'd1);
    check6("mid reset vsync", {5'b0, bus.vga_vsync}, 6'd1);
    check6("mid reset line_dropped", {5'b0, bus.line_dropped}, 6'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_line(0, 6'b000000);
    check_line(1, 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
